// File: rtl/accum17_ctrl.sv
// accum17_ctrl: sequencer for the 17-bit accumulator register and its
// multi-cycle adder. It takes the Clr / LoadSw / Run operator requests and
// runs exactly one operation per request assertion. After each operation it
// waits in HOLD until every request is released.
//
// Adder handshake: add_start is a one-cycle pulse issued from ADD_REQ. The
// adder answers with a one-cycle add_done pulse. add_done is acted on only
// when it is sampled in ADD_WAIT; a pulse seen in any other state is
// dropped. If add_done does not arrive within TIMEOUT ADD_WAIT cycles, the
// add is abandoned, nothing is written, and the sticky err flag is set.
module accum17_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Clr,
    input  logic             LoadSw,
    input  logic             Run,
    input  logic             add_done,
    output logic             add_start,
    output logic             reg_clr,
    output logic             reg_load,
    output logic             reg_sel,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] op_count,
    output logic [2:0]       state_dbg
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLEAR    = 3'd1,
        S_LOAD     = 3'd2,
        S_ADD_REQ  = 3'd3,
        S_ADD_WAIT = 3'd4,
        S_WRITE    = 3'd5,
        S_HOLD     = 3'd6
    } state_t;

    state_t        state, state_nx;
    logic [TW-1:0] timer;
    logic          timeout_hit;
    logic          any_req;

    assign timeout_hit = (timer == TW'(TIMEOUT - 1));
    assign any_req     = Clr | LoadSw | Run;
    assign state_dbg   = state;

    // State register; a reset abandons any operation in flight.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next state: fixed request priority Clr > LoadSw > Run. Every
    // operation ends in HOLD, so a request that stays high never retriggers.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (Clr)         state_nx = S_CLEAR;
                else if (LoadSw) state_nx = S_LOAD;
                else if (Run)    state_nx = S_ADD_REQ;
            end
            S_CLEAR:   state_nx = S_HOLD;
            S_LOAD:    state_nx = S_HOLD;
            S_ADD_REQ: state_nx = S_ADD_WAIT;
            S_ADD_WAIT: begin
                if (add_done)         state_nx = S_WRITE;
                else if (timeout_hit) state_nx = S_HOLD;
            end
            S_WRITE: state_nx = S_HOLD;
            S_HOLD: begin
                if (!any_req) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Moore strobes decoded from the state register only. reg_clr and
    // reg_load come from disjoint states, so they can never overlap.
    always_comb begin
        add_start = 1'b0;
        reg_clr   = 1'b0;
        reg_load  = 1'b0;
        reg_sel   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_CLEAR: begin
                reg_clr = 1'b1;
                busy    = 1'b1;
            end
            S_LOAD: begin
                reg_load = 1'b1;
                busy     = 1'b1;
            end
            S_ADD_REQ: begin
                add_start = 1'b1;
                busy      = 1'b1;
            end
            S_ADD_WAIT: begin
                reg_sel = 1'b1;
                busy    = 1'b1;
            end
            S_WRITE: begin
                reg_load = 1'b1;
                reg_sel  = 1'b1;
                done     = 1'b1;
                busy     = 1'b1;
            end
            default: ;
        endcase
    end

    // Watchdog timer: zeroed when the add is requested, then counts the
    // ADD_WAIT cycles that pass without add_done.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            timer <= '0;
        else if (state == S_ADD_REQ)
            timer <= '0;
        else if (state == S_ADD_WAIT && !add_done && !timeout_hit)
            timer <= timer + TW'(1);
    end

    // Sticky timeout flag: set when the watchdog expires; only CLEAR or
    // Reset clears it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            err <= 1'b0;
        else if (state == S_CLEAR)
            err <= 1'b0;
        else if (state == S_ADD_WAIT && !add_done && timeout_hit)
            err <= 1'b1;
    end

    // Completed-add counter: counts each WRITE, stops at all ones, and is
    // zeroed by CLEAR.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            op_count <= '0;
        else if (state == S_CLEAR)
            op_count <= '0;
        else if (state == S_WRITE && !(&op_count))
            op_count <= op_count + CNT_W'(1);
    end

endmodule
